hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central pipeline-control sequencer that drives the stall, bubble and flush inputs of the F/D, D/EX and EX/MEM pipeline registers.
- Detects load-use hazards and sequences data-memory miss freezes.
- Times multi-cycle multiplies held in EX.
- Qualifies the EX-stage branch-redirect flush against memory stalls.
- Sits beside the pipeline registers; contains no datapath.

Parameters:
- MUL_LAT, 3, total cycles a multiply occupies EX (≥1; 1 means no hold).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- D_rs1  in  5  decode-stage source register 1
- D_rs2  in  5  decode-stage source register 2
- D_use_rs1  in  1  decode instruction reads rs1
- D_use_rs2  in  1  decode instruction reads rs2
- EX_rd  in  5  destination register of the instruction in EX
- EX_ld  in  1  EX instruction is a load
- EX_we  in  1  EX instruction writes the register file
- EX_mul  in  1  EX instruction is a multiply
- EX_taken  in  1  EX resolved a redirect (mispredict)
- dmem_miss  in  1  MEM-stage access missed
- dmem_ready  in  1  refill complete; data valid this cycle
- stall_F  out  1  hold PC and the F/D register
- stall_D  out  1  insert a bubble into D/EX
- MEM_stall  out  1  hold D/EX and all upstream registers
- EX_bubble  out  1  write a bubble into EX/MEM
- EX_flush  out  1  qualified redirect: clear F/D and D/EX, load redirect PC
- mul_busy  out  1  multiply hold in progress
- perf_miss_cyc  out  CNT_W  optional counter
- perf_mul_cyc  out  CNT_W  optional counter
- perf_lu_bub  out  CNT_W  optional counter
- perf_flush  out  CNT_W  optional counter

Behaviour:
- FSM states: RUN, MISS, MUL. Reset enters RUN with mul_cnt=0. All outputs are 0 while rst_n=0. Reset asserted mid-MISS or mid-MUL aborts to RUN immediately.
- Outputs are combinational from state and inputs; state and counters are registered.

MISS sequencing:
- MEM_stall = dmem_miss | (state==MISS & !dmem_ready).
- RUN with dmem_miss → MISS. MISS with dmem_ready → RUN.
- dmem_miss and dmem_ready in the same RUN cycle means a hit-under-miss: MEM_stall=0 and the FSM stays in RUN.
- While MEM_stall=1: stall_F=1; stall_D, EX_bubble and EX_flush are forced to 0; mul_cnt is frozen.

MUL sequencing:
- RUN, EX_mul=1, MUL_LAT>1, no MEM_stall → load mul_cnt=MUL_LAT-2 and enter MUL. Hold is asserted this cycle.
- In MUL: hold is asserted each cycle. mul_cnt decrements when it is nonzero. mul_cnt==0 → RUN with hold=0 in the following cycle.
- The multiply therefore occupies EX exactly MUL_LAT cycles, with hold asserted during the first MUL_LAT-1.
- Hold effects: MEM_stall=1, stall_F=1, EX_bubble=1, mul_busy=1.
- dmem_miss during MUL: the MISS path has priority. The FSM stays in MUL and the counter freezes until the miss clears.

Load-use:
- lu = EX_ld & EX_we & EX_rd!=0 & ((D_use_rs1 & D_rs1==EX_rd) | (D_use_rs2 & D_rs2==EX_rd)).
- In RUN with no MEM_stall: stall_D=1 and stall_F=1 for exactly that one cycle. The next cycle, the load has moved to MEM and lu is naturally 0.

Redirect:
- EX_flush = EX_taken & !MEM_stall.
- EX_flush overrides lu: stall_D=0, stall_F=0.
- EX_taken under MEM_stall is deferred; the EX instruction is held and re-asserts EX_taken.

Output priority: rst_n > MEM_stall (miss) > mul hold > EX_flush > load-use.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: four CNT_W saturating counters, each cleared by rst_n.
  - miss cycles: count while MEM_stall from a miss.
  - mul hold cycles: count while mul_busy.
  - load-use bubbles: count cycles with stall_D=1.
  - EX_flush events: count cycles with EX_flush=1.
- Undefined: perf_* ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package hazard_ctrl_pkg:
  - state enum {RUN, MISS, MUL};
  - REG_ZERO = 5'd0;
  - function mul_cnt_w(MUL_LAT) = $clog2(MUL_LAT).
- One sub-module, hz_mul_timer: load/decrement/freeze counter with a done flag, parameterised by MUL_LAT.

Test Plan:
1. Load-use: EX_ld=1, EX_we=1, EX_rd=5, D_rs1=5, D_use_rs1=1 → stall_D=1 and stall_F=1 for one cycle, then 0. Repeat with EX_rd=0 → no stall.
2. Multiply, MUL_LAT=3: EX_mul asserted at cycle t → mul_busy/MEM_stall/EX_bubble=1 at t and t+1, 0 at t+2. perf_mul_cyc=2.
3. Miss: dmem_miss at t, dmem_ready at t+4 → MEM_stall=1 during t..t+3, 0 at t+4, state back to RUN. Same-cycle miss+ready → no stall.
4. EX_taken together with lu → EX_flush=1, stall_D=0, stall_F=0. EX_taken during a miss → EX_flush=0 until dmem_ready.
5. dmem_miss at mul cycle t+1 lasting 3 cycles → mul_cnt frozen; the multiply still holds exactly 2 non-miss cycles.
6. rst_n low mid-MUL and mid-MISS → all outputs 0 asynchronously. After release, state is RUN with counters at 0; with HAZ_PERF_CNT_EN, perf_* read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard_ctrl pipeline-control block.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    MUL  = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the multiply hold counter; never narrower than one bit so that
  // MUL_LAT of 1 or 2 still yields a legal vector.
  function automatic int mul_cnt_w(input int mul_lat);
    return (mul_lat > 2) ? $clog2(mul_lat) : 1;
  endfunction

endpackage

// File: rtl/hz_mul_timer.sv
// Multiply hold timer: loads MUL_LAT-2, counts down while enabled, freezes
// otherwise. done flags the final (non-hold) cycle of the multiply in EX.
module hz_mul_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec_en,
  output logic done
);

  localparam int CW    = mul_cnt_w(MUL_LAT);
  localparam int LOADV = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  logic [CW-1:0] cnt_q;

  // Counter register: load has priority, decrement only while enabled and nonzero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(LOADV);
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory miss freezes,
// multi-cycle multiply holds and redirect-flush qualification.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined;
// otherwise the perf_* ports are tied to zero.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic             D_use_rs1,
  input  logic             D_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_ld,
  input  logic             EX_we,
  input  logic             EX_mul,
  input  logic             EX_taken,
  input  logic             dmem_miss,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             MEM_stall,
  output logic             EX_bubble,
  output logic             EX_flush,
  output logic             mul_busy,
  output logic [CNT_W-1:0] perf_miss_cyc,
  output logic [CNT_W-1:0] perf_mul_cyc,
  output logic [CNT_W-1:0] perf_lu_bub,
  output logic [CNT_W-1:0] perf_flush
);

  localparam bit MUL_MULTI = (MUL_LAT > 1);

  state_e state_q, state_d;
  logic   lu;
  logic   miss_stall;
  logic   mul_load;
  logic   mul_hold;
  logic   mul_dec;
  logic   mul_done;

  // Ungated control decisions; the reset gate is applied only at the ports
  logic   stall_f_i, stall_d_i, mem_stall_i, ex_bubble_i, ex_flush_i, mul_busy_i;

  assign lu = EX_ld && EX_we && (EX_rd != REG_ZERO) &&
              ((D_use_rs1 && (D_rs1 == EX_rd)) || (D_use_rs2 && (D_rs2 == EX_rd)));

  // A miss that completes in the same RUN cycle is a hit-under-miss and never stalls
  assign miss_stall = (dmem_miss && !((state_q == RUN) && dmem_ready)) ||
                      ((state_q == MISS) && !dmem_ready);

  assign mul_load = (state_q == RUN) && EX_mul && !miss_stall && MUL_MULTI;
  // The last cycle of a multiply in EX (counter at zero) is not held
  assign mul_hold = mul_load || ((state_q == MUL) && !mul_done);
  assign mul_dec  = (state_q == MUL) && !miss_stall;

  hz_mul_timer #(
    .MUL_LAT (MUL_LAT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mul_load),
    .dec_en (mul_dec),
    .done   (mul_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a miss during MUL keeps the FSM in MUL with the timer frozen
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (miss_stall)    state_d = MISS;
        else if (mul_load) state_d = MUL;
      end
      MISS: begin
        if (dmem_ready) state_d = RUN;
      end
      MUL: begin
        if (!miss_stall && mul_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output priority: miss freeze, then multiply hold, then redirect, then load-use
  always_comb begin
    stall_f_i   = 1'b0;
    stall_d_i   = 1'b0;
    mem_stall_i = 1'b0;
    ex_bubble_i = 1'b0;
    ex_flush_i  = 1'b0;
    mul_busy_i  = 1'b0;
    if (miss_stall) begin
      mem_stall_i = 1'b1;
      stall_f_i   = 1'b1;
    end else if (mul_hold) begin
      mem_stall_i = 1'b1;
      stall_f_i   = 1'b1;
      ex_bubble_i = 1'b1;
      mul_busy_i  = 1'b1;
    end else if (EX_taken) begin
      ex_flush_i  = 1'b1;
    end else if (lu) begin
      stall_d_i   = 1'b1;
      stall_f_i   = 1'b1;
    end
  end

  assign stall_F   = rst_n & stall_f_i;
  assign stall_D   = rst_n & stall_d_i;
  assign MEM_stall = rst_n & mem_stall_i;
  assign EX_bubble = rst_n & ex_bubble_i;
  assign EX_flush  = rst_n & ex_flush_i;
  assign mul_busy  = rst_n & mul_busy_i;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] miss_cyc_q, mul_cyc_q, lu_bub_q, flush_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cyc_q <= '0;
      mul_cyc_q  <= '0;
      lu_bub_q   <= '0;
      flush_q    <= '0;
    end else begin
      miss_cyc_q <= sat_inc(miss_cyc_q, miss_stall);
      mul_cyc_q  <= sat_inc(mul_cyc_q,  mul_busy_i);
      lu_bub_q   <= sat_inc(lu_bub_q,   stall_d_i);
      flush_q    <= sat_inc(flush_q,    ex_flush_i);
    end
  end

  assign perf_miss_cyc = miss_cyc_q;
  assign perf_mul_cyc  = mul_cyc_q;
  assign perf_lu_bub   = lu_bub_q;
  assign perf_flush    = flush_q;
`else
  assign perf_miss_cyc = '0;
  assign perf_mul_cyc  = '0;
  assign perf_lu_bub   = '0;
  assign perf_flush    = '0;
`endif

endmodule
